peecc_run_scheduler: RTL and testbench

Run-level scheduler that sits above the pipeline sequencing controller in the PEECC evaluation datapath. It accepts a start command with a word count and a mask of encoder configurations, then sweeps the enabled configurations lowest-index first. For each configuration it reloads the data/error generator seed, issues one `pipe_valid` per word to the pipeline controller and waits for that controller's `pipe_done`. It reports per-configuration and whole-sweep completion, with an optional watchdog on the pipeline handshake.

---
 rtl/peecc_run_scheduler_if.sv | 31 +++
 rtl/peecc_run_scheduler.sv | 141 ++++++++++++++
 tb/tb_peecc_run_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/peecc_run_scheduler_if.sv
// Command, status and pipeline-handshake bundle for peecc_run_scheduler.
// The host/bench side uses master; the scheduler uses slave.
interface peecc_run_scheduler_if #(
  parameter int WORD_CNT_W = 16,
  parameter int NUM_CFG    = 4,
  parameter int CFG_W      = 2
);
  logic                  start;
  logic                  abort;
  logic [WORD_CNT_W-1:0] num_words;
  logic [NUM_CFG-1:0]    cfg_mask;
  logic                  pipe_done;
  logic                  pipe_valid;
  logic                  load_seed;
  logic [CFG_W-1:0]      cfg_sel;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic                  busy;
  logic                  run_done;
  logic                  all_done;
  logic                  timeout_err;

  modport master (
    output start, abort, num_words, cfg_mask, pipe_done,
    input  pipe_valid, load_seed, cfg_sel, word_cnt, busy, run_done, all_done, timeout_err
  );

  modport slave (
    input  start, abort, num_words, cfg_mask, pipe_done,
    output pipe_valid, load_seed, cfg_sel, word_cnt, busy, run_done, all_done, timeout_err
  );
endinterface

// File: rtl/peecc_run_scheduler.sv
// PEECC run scheduler: sweeps enabled encoder configurations, issuing one pipe_valid per word.
// Optional handshake watchdog enabled by defining PEECC_SCHED_TIMEOUT_EN.
module peecc_run_scheduler #(
  parameter int WORD_CNT_W = 16,
  parameter int NUM_CFG    = 4,
  parameter int CFG_W      = 2,
  parameter int TIMEOUT    = 64
) (
  input logic                   clk,
  input logic                   reset,
  peecc_run_scheduler_if.slave  sched
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEED   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]            state;
  logic [NUM_CFG-1:0]    pend_mask;
  logic [NUM_CFG-1:0]    pend_rem;
  logic [WORD_CNT_W-1:0] cnt_lat;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [WORD_CNT_W-1:0] word_inc;
  logic [CFG_W-1:0]      cfg_sel;
  logic                  wd_expire;

  function automatic logic [CFG_W-1:0] lowest_set(input logic [NUM_CFG-1:0] m);
    logic [CFG_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (m[i] && !found) begin
        idx   = CFG_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign word_inc = word_cnt + WORD_CNT_W'(1);
  assign pend_rem = pend_mask & ~(NUM_CFG'(1) << cfg_sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pend_mask <= '0;
      cnt_lat   <= '0;
      word_cnt  <= '0;
      cfg_sel   <= '0;
    end else if (sched.abort) begin
      // word_cnt/cfg_sel deliberately hold so software can see where the sweep stopped
      state     <= S_IDLE;
      pend_mask <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sched.start) begin
            cnt_lat   <= sched.num_words;
            pend_mask <= sched.cfg_mask;
            if ((|sched.num_words) && (|sched.cfg_mask)) begin
              cfg_sel <= lowest_set(sched.cfg_mask);
              state   <= S_SEED;
            end else begin
              state   <= S_FINISH;
            end
          end
        end
        S_SEED: begin
          word_cnt <= '0;
          state    <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (sched.pipe_done) begin
            word_cnt <= word_inc;
            state    <= (word_inc == cnt_lat) ? S_NEXT : S_ISSUE;
          end else if (wd_expire) begin
            state     <= S_IDLE;
            pend_mask <= '0;
          end
        end
        S_NEXT: begin
          pend_mask <= pend_rem;
          if (|pend_rem) begin
            cfg_sel <= lowest_set(pend_rem);
            state   <= S_SEED;
          end else begin
            state   <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef PEECC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd;
  logic            timeout_err;

  // Expiry needs a quiet WAIT cycle at the limit; a pipe_done in that cycle wins.
  assign wd_expire = (state == S_WAIT) && !sched.pipe_done && !sched.abort &&
                     (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd <= '0;
      else if ((state == S_WAIT) && !sched.pipe_done && !sched.abort)
        wd <= wd + WD_W'(1);
      if (wd_expire)
        timeout_err <= 1'b1;
      else if ((state == S_IDLE) && sched.start && !sched.abort)
        timeout_err <= 1'b0;
    end
  end

  assign sched.timeout_err = timeout_err;
`else
  assign wd_expire         = 1'b0;
  assign sched.timeout_err = 1'b0;
`endif

  assign sched.busy       = (state != S_IDLE);
  assign sched.load_seed  = (state == S_SEED);
  assign sched.pipe_valid = (state == S_ISSUE);
  assign sched.run_done   = (state == S_NEXT);
  assign sched.all_done   = (state == S_FINISH);
  assign sched.cfg_sel    = cfg_sel;
  assign sched.word_cnt   = word_cnt;

endmodule

// File: tb/tb_peecc_run_scheduler.sv
// Self-checking bench for peecc_run_scheduler: randomized sweeps scored against
// an event-level model (config order, pulse counts, busy length from chosen delays).
module tb_peecc_run_scheduler;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_pass;

  peecc_run_scheduler_if #(.WORD_CNT_W(16), .NUM_CFG(4), .CFG_W(2)) sif ();

  peecc_run_scheduler #(
    .WORD_CNT_W(16),
    .NUM_CFG   (4),
    .CFG_W     (2),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sched(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got still running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_vec();
    return {8'h00, sif.pipe_valid, sif.load_seed, sif.cfg_sel, sif.word_cnt,
            sif.busy, sif.run_done, sif.all_done, sif.timeout_err};
  endfunction

  // One sweep with a randomly delaying pipeline and junk on ignored inputs.
  task automatic run_sweep(input logic [3:0] mask, input logic [15:0] n, input int unsigned fixed_d);
    int unsigned exp_cfg[$];
    int unsigned ci = 0, words = 0, dly = 0, cyc = 0;
    int unsigned busy_cyc = 0, exp_busy = 1;
    int unsigned seeds = 0, valids = 0, runs = 0, alls = 0;
    bit          fin = 0;
    for (int unsigned i = 0; i < 4; i++)
      if (mask[i] && n != 0) exp_cfg.push_back(i);
    sif.start     = 1'b1;
    sif.num_words = n;
    sif.cfg_mask  = mask;
    tick();
    sif.start = 1'b0;
    while (!fin) begin
      if (!sif.busy) begin
        fin = 1;
      end else begin
        busy_cyc++;
        sif.pipe_done = 1'b0;
        sif.start     = ($urandom_range(0, 3) == 0);
        sif.num_words = 16'($urandom);
        sif.cfg_mask  = 4'($urandom);
        if (sif.load_seed) begin
          seeds++;
          if (ci < exp_cfg.size()) check("seed_cfg", 32'(sif.cfg_sel), exp_cfg[ci]);
          else check("seed_extra", ci, exp_cfg.size());
          ci++;
          words = 0;
          exp_busy += 2;
        end else if (sif.pipe_valid) begin
          valids++;
          check("issue_wcnt", 32'(sif.word_cnt), words);
          words++;
          dly = (fixed_d != 0) ? fixed_d : $urandom_range(1, 3);
          exp_busy += 1 + dly;
        end else if (sif.run_done) begin
          runs++;
          check("next_wcnt", 32'(sif.word_cnt), 32'(n));
        end else if (sif.all_done) begin
          alls++;
        end else begin
          if (dly > 0) dly--;
          if (dly == 0) sif.pipe_done = 1'b1;
        end
        if ((sif.load_seed || sif.pipe_valid || sif.run_done || sif.all_done) &&
            $urandom_range(0, 2) == 0)
          sif.pipe_done = 1'b1;
        tick();
        cyc++;
        if (cyc > 400) begin
          check("sweep_bound", cyc, 400);
          fin = 1;
        end
      end
    end
    sif.start     = 1'b0;
    sif.pipe_done = 1'b0;
    check("n_seed",   seeds,  exp_cfg.size());
    check("n_valid",  valids, exp_cfg.size() * 32'(n));
    check("n_run",    runs,   exp_cfg.size());
    check("n_all",    alls,   1);
    check("busy_len", busy_cyc, exp_busy);
    check("no_tmo",   32'(sif.timeout_err), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    sif.abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.start = 1'($urandom); sif.abort = 1'($urandom); sif.pipe_done = 1'($urandom);
      sif.num_words = 16'($urandom); sif.cfg_mask = 4'($urandom);
      tick();
      check("rst_outs", outs_vec(), 0);
    end
    sif.start = 1'b0; sif.abort = 1'b0; sif.pipe_done = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_outs", outs_vec(), 0);

    run_sweep(4'b0000, 16'd5, 0);
    run_sweep(4'b1111, 16'd0, 0);
    run_sweep(4'b0100, 16'd3, 1);
    run_sweep(4'b1011, 16'd2, 0);
    run_sweep(4'b1000, 16'd1, 0);
    for (int r = 0; r < 10; r++)
      run_sweep(4'($urandom), 16'($urandom_range(1, 4)), 0);

    // abort coinciding with pipe_done on the second word
    sif.start = 1'b1; sif.num_words = 16'd3; sif.cfg_mask = 4'b1000;
    tick();
    sif.start = 1'b0;
    check("ab_seed", {sif.load_seed, 30'd0, 1'b0} | 32'(sif.cfg_sel), 32'h8000_0003);
    tick();
    check("ab_issue", 32'(sif.pipe_valid), 1);
    tick();
    sif.pipe_done = 1'b1;
    tick();
    sif.pipe_done = 1'b0;
    check("ab_wcnt1", 32'(sif.word_cnt), 1);
    tick();
    sif.pipe_done = 1'b1; sif.abort = 1'b1;
    tick();
    sif.pipe_done = 1'b0; sif.abort = 1'b0;
    check("ab_idle", 32'(sif.busy), 0);
    check("ab_wcnt", 32'(sif.word_cnt), 1);
    check("ab_cfg",  32'(sif.cfg_sel), 3);
    for (int i = 0; i < 3; i++) begin
      check("ab_quiet", {29'd0, sif.busy, sif.run_done, sif.all_done}, 0);
      tick();
    end

    // asynchronous reset in the middle of a sweep
    sif.start = 1'b1; sif.num_words = 16'd3; sif.cfg_mask = 4'b0010;
    tick();
    sif.start = 1'b0;
    tick(); tick();
    check("mid_busy", {sif.busy, 30'd0, sif.cfg_sel[0]}, 32'h8000_0001);
    #2 reset = 1'b0;
    #1 check("mid_rst", outs_vec(), 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst", outs_vec(), 0);

    // pipeline that never answers
    sif.start = 1'b1; sif.num_words = 16'd2; sif.cfg_mask = 4'b0001;
    tick();
    sif.start = 1'b0;
    tick();
    begin
      int unsigned waits = 0;
      int unsigned dones = 0;
      tick();
      while (sif.busy && waits < 40) begin
        waits++;
        dones += sif.run_done + sif.all_done;
        tick();
      end
      check("wd_dones", dones, 0);
`ifdef PEECC_SCHED_TIMEOUT_EN
      check("wd_waits", waits, 8);
      check("wd_err", 32'(sif.timeout_err), 1);
      check("wd_idle", 32'(sif.busy), 0);
      sif.start = 1'b1; sif.cfg_mask = 4'b0000;
      tick();
      sif.start = 1'b0;
      check("wd_clr", 32'(sif.timeout_err), 0);
      tick();
`else
      check("hang_waits", waits, 40);
      check("hang_busy", 32'(sif.busy), 1);
      check("hang_err", 32'(sif.timeout_err), 0);
      sif.abort = 1'b1;
      tick();
      sif.abort = 1'b0;
      check("hang_abort", 32'(sif.busy), 0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
